vga_dither_out: RTL

VGA_DITHER_OUT -- requirements
Module: vga_dither_out

---
 rtl/vga_dither_out_pkg.sv | 37 +++
 rtl/vga_dither_out_channel.sv | 22 ++
 rtl/vga_dither_out.sv | 139 +++++++++++++
 3 files changed

// File: rtl/vga_dither_out_pkg.sv
// Shared constants for the VGA dither output stage: channel widths, pin
// positions on the 8-bit VGA connector and the 4x4 Bayer threshold table.
package vga_dither_out_pkg;

  localparam int CH_IN_W  = 4;
  localparam int CH_OUT_W = 2;

  // [1] is the channel MSB, [0] the LSB on the resistor ladder.
  localparam int VGA_R1_BIT = 0;
  localparam int VGA_G1_BIT = 1;
  localparam int VGA_B1_BIT = 2;
  localparam int VGA_VS_BIT = 3;
  localparam int VGA_R0_BIT = 4;
  localparam int VGA_G0_BIT = 5;
  localparam int VGA_B0_BIT = 6;
  localparam int VGA_HS_BIT = 7;

  localparam logic [3:0] BAYER4 [16] = '{
    4'd0,  4'd8,  4'd2,  4'd10,
    4'd12, 4'd4,  4'd14, 4'd6,
    4'd3,  4'd11, 4'd1,  4'd9,
    4'd15, 4'd7,  4'd13, 4'd5
  };

  typedef logic [CH_OUT_W-1:0] chan_out_t;

  typedef struct packed {
    chan_out_t r;
    chan_out_t g;
    chan_out_t b;
  } rgb_out_t;

  function automatic logic [3:0] bayerThreshold(input logic [1:0] row, input logic [1:0] col);
    return BAYER4[{row, col}];
  endfunction

endpackage

// File: rtl/vga_dither_out_channel.sv
// One colour channel: 4-bit intensity reduced to 2 bits, either by ordered
// dither against a Bayer threshold or by plain truncation.
module dither_channel
  import vga_dither_out_pkg::*;
(
  input  logic [CH_IN_W-1:0]  i_c,
  input  logic [3:0]          i_t,
  input  logic                i_ditherEn,
  output logic [CH_OUT_W-1:0] o_q
);

  logic [5:0] w_scaled;
  logic [1:0] w_dithered;

  // 3*c + c[3:2] spreads 0..15 onto 0..48 so that adding any threshold
  // 0..15 and dropping four bits lands exactly on 0..3 with no clamp.
  assign w_scaled   = {1'b0, i_c, 1'b0} + {2'b00, i_c} + {4'b0000, i_c[3:2]};
  assign w_dithered = 2'((w_scaled + {2'b00, i_t}) >> 4);

  assign o_q = i_ditherEn ? w_dithered : i_c[3:2];

endmodule

// File: rtl/vga_dither_out.sv
// PPU-to-VGA output stage: two-cycle pipeline that reduces 12-bit colour to
// 6 pins with ordered (optionally frame-rotated) dither and delays the syncs.
module vga_dither_out
  import vga_dither_out_pkg::*;
#(
  parameter  logic SYNC_ACTIVE = 1'b0,
  localparam int   LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] rgb_in,
  input  logic        active_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        dither_en,
  input  logic        temporal_en,
  output logic [7:0]  vga_out
);

  logic [11:0]        r_rgb;
  logic               r_active;
  logic               r_ditherEn;
  logic               r_temporalEn;
  logic [LATENCY-1:0] r_hsPipe;
  logic [LATENCY-1:0] r_vsPipe;
  logic               r_hsPrev;
  logic               r_vsPrev;
  logic [1:0]         r_xCnt;
  logic [1:0]         r_yCnt;
  logic [1:0]         r_frameCnt;
  rgb_out_t           r_pix;

  logic               w_hsEdge;
  logic               w_vsEdge;
  logic [1:0]         w_xEff;
  logic [3:0]         w_threshold;
  chan_out_t          w_qR;
  chan_out_t          w_qG;
  chan_out_t          w_qB;

  // Syncs reset to the idle level so no edge is seen when reset lifts mid-line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rgb        <= '0;
      r_active     <= 1'b0;
      r_ditherEn   <= 1'b0;
      r_temporalEn <= 1'b0;
      r_hsPipe     <= {LATENCY{~SYNC_ACTIVE}};
      r_vsPipe     <= {LATENCY{~SYNC_ACTIVE}};
      r_hsPrev     <= ~SYNC_ACTIVE;
      r_vsPrev     <= ~SYNC_ACTIVE;
    end else begin
      r_rgb        <= rgb_in;
      r_active     <= active_in;
      r_ditherEn   <= dither_en;
      r_temporalEn <= temporal_en;
      r_hsPipe     <= {r_hsPipe[LATENCY-2:0], hsync_in};
      r_vsPipe     <= {r_vsPipe[LATENCY-2:0], vsync_in};
      r_hsPrev     <= r_hsPipe[0];
      r_vsPrev     <= r_vsPipe[0];
    end
  end

  assign w_hsEdge = (r_hsPipe[0] == SYNC_ACTIVE) && (r_hsPrev != SYNC_ACTIVE);
  assign w_vsEdge = (r_vsPipe[0] == SYNC_ACTIVE) && (r_vsPrev != SYNC_ACTIVE);

  // The pixel in stage 1 uses the counters before this cycle's update,
  // so the first visible pixel after an hsync edge sits at x=0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_xCnt     <= 2'd0;
      r_yCnt     <= 2'd0;
      r_frameCnt <= 2'd0;
    end else begin
      if (w_hsEdge) begin
        r_xCnt <= 2'd0;
      end else if (r_active) begin
        r_xCnt <= r_xCnt + 2'd1;
      end

      if (w_vsEdge) begin
        r_yCnt <= 2'd0;
      end else if (w_hsEdge) begin
        r_yCnt <= r_yCnt + 2'd1;
      end

      if (w_vsEdge) begin
        r_frameCnt <= r_frameCnt + 2'd1;
      end
    end
  end

  assign w_xEff      = r_temporalEn ? (r_xCnt ^ r_frameCnt) : r_xCnt;
  assign w_threshold = bayerThreshold(r_yCnt, w_xEff);

  dither_channel u_chanR (
    .i_c       (r_rgb[11:8]),
    .i_t       (w_threshold),
    .i_ditherEn(r_ditherEn),
    .o_q       (w_qR)
  );

  dither_channel u_chanG (
    .i_c       (r_rgb[7:4]),
    .i_t       (w_threshold),
    .i_ditherEn(r_ditherEn),
    .o_q       (w_qG)
  );

  dither_channel u_chanB (
    .i_c       (r_rgb[3:0]),
    .i_t       (w_threshold),
    .i_ditherEn(r_ditherEn),
    .o_q       (w_qB)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix <= '0;
    end else if (r_active) begin
      r_pix <= '{r: w_qR, g: w_qG, b: w_qB};
    end else begin
      r_pix <= '0;
    end
  end

  always_comb begin
    vga_out             = '0;
    vga_out[VGA_HS_BIT] = r_hsPipe[LATENCY-1];
    vga_out[VGA_VS_BIT] = r_vsPipe[LATENCY-1];
    vga_out[VGA_R0_BIT] = r_pix.r[0];
    vga_out[VGA_G0_BIT] = r_pix.g[0];
    vga_out[VGA_B0_BIT] = r_pix.b[0];
    vga_out[VGA_R1_BIT] = r_pix.r[1];
    vga_out[VGA_G1_BIT] = r_pix.g[1];
    vga_out[VGA_B1_BIT] = r_pix.b[1];
  end

endmodule
